// File: rtl/ibex_pext_simd_mult_if.sv
// Mode encoding and request/response bundle for the P-extension packed multiplier.
// The package sits in this file so that the interface and the core share one definition.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        M8x8   = 2'd0,
        M16x16 = 2'd1,
        M32x16 = 2'd2,
        M32x32 = 2'd3
    } mult_pext_mode_e;

endpackage

interface ibex_pext_simd_mult_if;
    import ibex_pkg_pext::*;

    logic            valid_i;
    logic            ready_o;
    mult_pext_mode_e mode_i;
    logic [31:0]     op_a_i;
    logic [31:0]     op_b_i;
    logic            signed_a_i;
    logic            signed_b_i;
    logic            acc_en_i;
    logic            sat_en_i;
    logic [63:0]     acc_i;
    logic            kill_i;
    logic            valid_o;
    logic            ready_i;
    logic [63:0]     result_o;
    logic            ov_o;

    modport master (
        output valid_i, mode_i, op_a_i, op_b_i, signed_a_i, signed_b_i,
               acc_en_i, sat_en_i, acc_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o, ov_o
    );

    modport slave (
        input  valid_i, mode_i, op_a_i, op_b_i, signed_a_i, signed_b_i,
               acc_en_i, sat_en_i, acc_i, kill_i, ready_i,
        output ready_o, valid_o, result_o, ov_o
    );

endinterface

// File: rtl/ibex_pext_simd_mult.sv
// Multi-cycle packed multiplier: 16x16 units time-multiplexed over MUL_SLICES 17x17 signed
// slices, with optional lane-wise wrapping or saturating accumulate.
module ibex_pext_simd_mult
    import ibex_pkg_pext::*;
#(
    parameter int MUL_SLICES = 2
) (
    input logic                   clk_i,
    input logic                   rst_i,
    ibex_pext_simd_mult_if.slave  bus
);

    if (!(MUL_SLICES == 1 || MUL_SLICES == 2 || MUL_SLICES == 4)) begin : g_bad_slices
        $error("ibex_pext_simd_mult: MUL_SLICES must be 1, 2 or 4");
    end

    localparam int GROUPS4 = (4 + MUL_SLICES - 1) / MUL_SLICES;
    localparam int GROUPS2 = (2 + MUL_SLICES - 1) / MUL_SLICES;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     op_a_q, op_b_q;
    mult_pext_mode_e mode_q;
    logic            sa_q, sb_q, acc_en_q, sat_en_q;
    logic [63:0]     acc_q;
    logic [63:0]     partial_q;
    logic [1:0]      grp_q;
    logic [63:0]     result_q;
    logic            ov_q;
    logic            valid_q;

    logic            accept, abort, finish, drop;
    logic            four_units;
    logic [2:0]      num_units;
    logic [1:0]      last_grp;
    logic [2:0]      unit_idx;
    logic [63:0]     slice_sum, prod_full, prod_ext, acc_result;
    logic [64:0]     lane_res;
    logic            acc_ov;
    logic            sat_signed;

    // One 16x16 unit on a 17x17 signed slice; the product is returned already placed
    // at its lane or partial-product position.
    function automatic logic [63:0] unit_product(input mult_pext_mode_e mode, input logic [1:0] k,
                                                 input logic [31:0] a, input logic [31:0] b,
                                                 input logic sa, input logic sb);
        logic [7:0]         a8, b8;
        logic [15:0]        a16, b16;
        logic signed [16:0] x, y;
        logic signed [33:0] p;
        logic               hi_a, hi_b;
        logic [63:0]        wide;
        logic [63:0]        res;
        a8   = a[{k, 3'b000} +: 8];
        b8   = b[{k, 3'b000} +: 8];
        a16  = a[{k[0], 4'b0000} +: 16];
        b16  = b[{k[0], 4'b0000} +: 16];
        hi_a = 1'b0;
        hi_b = 1'b0;
        case (mode)
            M8x8: begin
                x = {{9{sa & a8[7]}}, a8};
                y = {{9{sb & b8[7]}}, b8};
            end
            M16x16: begin
                x = {sa & a16[15], a16};
                y = {sb & b16[15], b16};
            end
            M32x16: begin
                hi_a = k[0];
                x    = hi_a ? {sa & a[31], a[31:16]} : {1'b0, a[15:0]};
                y    = {sb & b[15], b[15:0]};
            end
            default: begin
                hi_a = k[1];
                hi_b = k[0];
                x    = hi_a ? {sa & a[31], a[31:16]} : {1'b0, a[15:0]};
                y    = hi_b ? {sb & b[31], b[31:16]} : {1'b0, b[15:0]};
            end
        endcase
        p    = x * y;
        wide = {{30{p[33]}}, p};
        case (mode)
            M8x8:    res = {48'b0, p[15:0]} << {k, 4'b0000};
            M16x16:  res = {32'b0, p[31:0]} << {k[0], 5'b00000};
            default: res = wide << {({1'b0, hi_a} + {1'b0, hi_b}), 4'b0000};
        endcase
        return res;
    endfunction

    // Lane add at width w: both operands are left-aligned so that the carry and sign
    // bits of every lane width sit at the same positions. Returns {clamped, sum}.
    function automatic logic [64:0] acc_lane(input logic [63:0] p, input logic [63:0] a,
                                             input logic [6:0] w, input logic sgn, input logic sat);
        logic [63:0] pl, al, r;
        logic [64:0] s;
        logic        ov;
        pl = p << (7'd64 - w);
        al = a << (7'd64 - w);
        s  = {1'b0, pl} + {1'b0, al};
        r  = s[63:0];
        ov = 1'b0;
        if (sat) begin
            if (sgn) begin
                if (pl[63] == al[63] && r[63] != pl[63]) begin
                    r  = pl[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
                    ov = 1'b1;
                end
            end else if (s[64]) begin
                r  = '1;
                ov = 1'b1;
            end
        end
        return {ov, r >> (7'd64 - w)};
    endfunction

    assign four_units = (mode_q == M8x8) || (mode_q == M32x32);
    assign num_units  = four_units ? 3'd4 : 3'd2;
    assign last_grp   = four_units ? 2'(GROUPS4 - 1) : 2'(GROUPS2 - 1);
    assign sat_signed = sa_q | sb_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a path that
        // skips the assignment makes synthesis infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        finish  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: if (bus.valid_i && !bus.kill_i) begin
                accept  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (bus.kill_i) begin
                abort   = 1'b1;
                state_d = IDLE;
            end else if (grp_q == last_grp) begin
                finish  = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.kill_i || bus.ready_i) begin
                drop    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slice_sum = '0;
        unit_idx  = '0;
        for (int s = 0; s < MUL_SLICES; s++) begin
            unit_idx = 3'(int'(grp_q) * MUL_SLICES + s);
            if (unit_idx < num_units) begin
                slice_sum = slice_sum + unit_product(mode_q, unit_idx[1:0], op_a_q, op_b_q, sa_q, sb_q);
            end
        end
    end

    assign prod_full = partial_q + slice_sum;

    always_comb begin
        prod_ext = prod_full;
        if (mode_q == M32x16) begin
            prod_ext = {{16{sat_signed & prod_full[47]}}, prod_full[47:0]};
        end
    end

    always_comb begin
        acc_result = prod_ext;
        acc_ov     = 1'b0;
        lane_res   = '0;
        if (acc_en_q) begin
            case (mode_q)
                M8x8: for (int i = 0; i < 4; i++) begin
                    lane_res = acc_lane({48'b0, prod_ext[16*i +: 16]}, {48'b0, acc_q[16*i +: 16]},
                                        7'd16, sat_signed, sat_en_q);
                    acc_result[16*i +: 16] = lane_res[15:0];
                    acc_ov = acc_ov | lane_res[64];
                end
                M16x16: for (int i = 0; i < 2; i++) begin
                    lane_res = acc_lane({32'b0, prod_ext[32*i +: 32]}, {32'b0, acc_q[32*i +: 32]},
                                        7'd32, sat_signed, sat_en_q);
                    acc_result[32*i +: 32] = lane_res[31:0];
                    acc_ov = acc_ov | lane_res[64];
                end
                default: begin
                    lane_res   = acc_lane(prod_ext, acc_q, 7'd64, sat_signed, sat_en_q);
                    acc_result = lane_res[63:0];
                    acc_ov     = lane_res[64];
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the values from
    // before the edge, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            mode_q    <= M8x8;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            acc_en_q  <= 1'b0;
            sat_en_q  <= 1'b0;
            acc_q     <= '0;
            partial_q <= '0;
            grp_q     <= '0;
            result_q  <= '0;
            ov_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q    <= bus.op_a_i;
                op_b_q    <= bus.op_b_i;
                mode_q    <= bus.mode_i;
                sa_q      <= bus.signed_a_i;
                sb_q      <= bus.signed_b_i;
                acc_en_q  <= bus.acc_en_i;
                sat_en_q  <= bus.sat_en_i;
                acc_q     <= bus.acc_i;
                partial_q <= '0;
                grp_q     <= '0;
            end else if (abort) begin
                partial_q <= '0;
                grp_q     <= '0;
            end else if (finish) begin
                result_q  <= acc_result;
                ov_q      <= acc_ov;
                valid_q   <= 1'b1;
                partial_q <= '0;
                grp_q     <= '0;
            end else if (state_q == BUSY) begin
                partial_q <= prod_full;
                grp_q     <= grp_q + 2'd1;
            end
            if (drop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.ov_o     = ov_q;

endmodule

// File: doc/ibex_pext_simd_mult.md
Name: ibex_pext_simd_mult

Overview:
- Multi-cycle, parametrised packed multiplier for the P-extension multiply/multiply-accumulate ops in the ALU/MD stage.
- Supports the four mult_pext_mode_e modes: M8x8 (4 lanes), M16x16 (2 lanes), M32x16 and M32x32.
- Work is decomposed into 16x16 units and time-multiplexed over MUL_SLICES 17x17 signed multiplier slices.
- Optional lane-wise accumulate with signed/unsigned saturation and overflow flag.

Parameters:
MUL_SLICES, 2, number of 17x17 signed multiplier slices; legal values 1, 2, 4 (any other value is a static assertion failure).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  request valid
ready_o  out  1  block can accept a request (high only in IDLE)
mode_i  in  2  ibex_pkg_pext::mult_pext_mode_e
op_a_i  in  32  operand A
op_b_i  in  32  operand B
signed_a_i  in  1  treat A lanes/halves as signed
signed_b_i  in  1  treat B lanes/halves as signed
acc_en_i  in  1  add acc_i to product
sat_en_i  in  1  saturate accumulation (signedness = signed_a_i|signed_b_i)
acc_i  in  64  accumulator operand
kill_i  in  1  abort in-flight op (flush)
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  64  packed result
ov_o  out  1  saturation occurred in any lane of this result

Behaviour:
- Reset (async, any state):
  - state=IDLE; valid_o=0; result_o=0; ov_o=0; ready_o=1.
  - All operand, partial-sum and counter registers cleared.
- FSM states IDLE, BUSY, DONE.
  - IDLE→BUSY on valid_i&&ready_o; operands, mode and flags are latched on that edge (t0).
  - BUSY: group counter j runs 0..N-1. Each cycle processes units k in [j*MUL_SLICES, (j+1)*MUL_SLICES) and adds the shifted products into a 64-bit partial register.
  - BUSY→DONE at the edge ending group N-1. On that edge result_o and ov_o are registered (accumulate and saturate applied) and valid_o=1.
  - Result therefore appears exactly N cycles after t0.
  - DONE: result_o, ov_o and valid_o are held stable until ready_i. DONE→IDLE on ready_i (valid_o falls). A new request cannot be accepted in the same cycle (ready_o=0 in DONE).
- Units and N = ceil(units/MUL_SLICES):
  - M8x8: 4 units. Lane i = A[8i+7:8i]*B[8i+7:8i], each lane 16 bits. result_o = {p3,p2,p1,p0}.
  - M16x16: 2 units. Lane i = A[16i+15:16i]*B[16i+15:16i], each lane 32 bits.
  - M32x16: 2 units: AL*BL, AH*BL<<16. 48-bit product is sign-extended to 64 if signed_a_i|signed_b_i, else zero-extended.
  - M32x32: 4 units: AL*BL, AL*BH<<16, AH*BL<<16, AH*BH<<32. 64-bit result.
  - Unit order is as listed.
- Operand extension to 17 bits:
  - Low halves are always zero-extended.
  - High halves and 8/16-bit lanes are sign-extended when the corresponding signed_*_i is set.
  - For M32x16, BL is sign-extended per signed_b_i.
- Accumulate (acc_en_i=1):
  - Lane-wise add at lane width: 16-bit for M8x8, 32-bit for M16x16, 64-bit otherwise.
  - Without sat_en_i the add wraps; ov_o=0.
  - With sat_en_i, each lane clamps to signed or unsigned max/min and ov_o=1 if any lane clamped.
  - Without acc_en_i, ov_o=0.
- kill_i:
  - In BUSY: return to IDLE next edge, no valid_o, partial register cleared.
  - In DONE: drop result (valid_o=0 next cycle, →IDLE).
  - In IDLE: a request in the same cycle is not accepted.
  - kill_i has priority over valid_i and ready_i.
- Latched operands are used exclusively during BUSY; input changes after t0 have no effect.

Test Plan:
- MUL_SLICES=2, M32x32 signed, A=0xFFFFFFFF, B=0x00000002 -> result_o=0xFFFFFFFF_FFFFFFFE, valid_o rises exactly 2 cycles after accept; rerun with MUL_SLICES=1 (4 cycles) and 4 (1 cycle).
- M8x8, A=0xFF800302, B=0xFF800504: unsigned -> 0xFE01_4000_000F_0008; signed -> 0x0001_4000_000F_0008.
- M16x16 signed, acc_en=sat_en=1, A=0x7FFF0002, B=0x7FFF0003, acc_i=0x7FFFFFFF_0000000A -> result_o=0x7FFFFFFF_00000010, ov_o=1; same with sat_en=0 -> 0xBFFF0000_00000010, ov_o=0.
- Backpressure: ready_i=0 for 5 cycles in DONE -> result_o/valid_o/ov_o stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE, next request accepted the following cycle.
- kill_i one cycle after accept (M32x32, MUL_SLICES=1) -> no valid_o ever; ready_o=1 next cycle; back-to-back op yields a correct, uncontaminated result.
- rst_i asserted mid-BUSY (asynchronously, between edges) -> valid_o=0, result_o=0, ov_o=0 immediately; after release, a fresh M32x16 unsigned A=0x00010000, B=0x0000FFFF -> 0x00000000_FFFF0000.
